// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command path: navigation codes,
// packet geometry, the wheel mapping and the packet checksum.
package motor_pkg;

  typedef enum logic [3:0] {
    IDLE_BASE   = 4'd0,
    FORWARDS    = 4'd1,
    TURN        = 4'd2,
    TO_TABLE    = 4'd3,
    AT_TABLE    = 4'd4,
    BACKWARDS   = 4'd5,
    TURN_BACK   = 4'd6,
    RETURN_HOME = 4'd7,
    STOP        = 4'd8
  } nav_state_e;

  localparam int unsigned PKT_BYTES = 4;

  // Returns {left, right} as two's-complement bytes; magnitude must be <= 127.
  function automatic logic [15:0] wheel_cmd(input logic [3:0] direction,
                                            input logic [7:0] magnitude);
    logic [7:0] pos;
    logic [7:0] neg;
    pos = magnitude;
    neg = ~magnitude + 8'd1;
    case (direction)
      FORWARDS, TO_TABLE:     wheel_cmd = {pos, pos};
      TURN:                   wheel_cmd = {neg, pos};
      BACKWARDS, RETURN_HOME: wheel_cmd = {neg, neg};
      TURN_BACK:              wheel_cmd = {pos, neg};
      default:                wheel_cmd = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] pkt_checksum(input logic [7:0] header,
                                              input logic [7:0] left,
                                              input logic [7:0] right);
    pkt_checksum = header ^ left ^ right;
  endfunction

endpackage

// File: rtl/motor_command_sequencer_uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, line idles high.
// The last two cycles of the stop bit are spent in the idle state, so a caller
// that re-arms tx_valid one cycle after tx_ready rises gets exactly
// 10*CLKS_PER_BIT cycles per byte with no gap. Needs CLKS_PER_BIT >= 3.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(CLKS_PER_BIT - 3);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  tx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;

  assign tx_ready = (state_q == StIdle);

  // Bit timing and serialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tx_valid) begin
            shift_q <= data;
            cnt_q   <= '0;
            tx      <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == StopLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/motor_command_sequencer.sv
// Maps navigation state and speed to signed wheel commands and sends them as
// a 4-byte checksummed UART packet, on change and as a periodic keep-alive.
module motor_command_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned SPEED_W        = 3,
  parameter int unsigned SPEED_STEP     = 16,
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter logic [7:0]  HEADER         = 8'hAA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  output logic               uart_out,
  output logic               busy,
  output logic               pending,
  output logic [15:0]        pkt_count,
  output logic [7:0]         last_left,
  output logic [7:0]         last_right
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
  localparam logic [1:0] ByteLast = 2'(PKT_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitTx, StDone} seq_state_e;

  seq_state_e         state_q;
  logic               sent_valid_q;
  logic [3:0]         sent_dir_q;
  logic [SPEED_W-1:0] sent_spd_q;
  logic [3:0]         prev_dir_q;
  logic [SPEED_W-1:0] prev_spd_q;
  logic [RefW-1:0]    refresh_q;
  logic [1:0]         byte_idx_q;
  logic [7:0]         ck_q;
  logic               tx_valid_q;

  logic [15:0] mag_full;
  logic [7:0]  mag;
  logic [15:0] cmd;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        changed;
  logic        moved;

  // Wheel command and change detection from the live inputs.
  always_comb begin
    mag_full = 16'(speed) * 16'(SPEED_STEP);
    mag      = (mag_full > 16'd127) ? 8'd127 : mag_full[7:0];
    cmd      = wheel_cmd(direction, mag);
    changed  = {direction, speed} != {sent_dir_q, sent_spd_q};
    moved    = {direction, speed} != {prev_dir_q, prev_spd_q};
  end

  // Byte currently offered to the transmitter.
  always_comb begin
    tx_byte = HEADER;
    case (byte_idx_q)
      2'd0:    tx_byte = HEADER;
      2'd1:    tx_byte = last_left;
      2'd2:    tx_byte = last_right;
      default: tx_byte = ck_q;
    endcase
  end

  // Packet sequencing, status and keep-alive timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sent_valid_q <= 1'b0;
      sent_dir_q   <= '0;
      sent_spd_q   <= '0;
      prev_dir_q   <= '0;
      prev_spd_q   <= '0;
      refresh_q    <= '0;
      byte_idx_q   <= '0;
      ck_q         <= '0;
      tx_valid_q   <= 1'b0;
      busy         <= 1'b0;
      pending      <= 1'b0;
      pkt_count    <= '0;
      last_left    <= '0;
      last_right   <= '0;
    end else begin
      prev_dir_q <= direction;
      prev_spd_q <= speed;
      unique case (state_q)
        StIdle: begin
          if (!sent_valid_q || changed || refresh_q == RefLast) begin
            state_q <= StLoad;
          end else begin
            refresh_q <= refresh_q + RefW'(1);
          end
        end
        StLoad: begin
          sent_valid_q <= 1'b1;
          sent_dir_q   <= direction;
          sent_spd_q   <= speed;
          last_left    <= cmd[15:8];
          last_right   <= cmd[7:0];
          ck_q         <= pkt_checksum(HEADER, cmd[15:8], cmd[7:0]);
          busy         <= 1'b1;
          refresh_q    <= '0;
          byte_idx_q   <= '0;
          tx_valid_q   <= 1'b1;
          state_q      <= StSend;
        end
        StSend: begin
          if (moved) pending <= 1'b1;
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StWaitTx;
          end
        end
        StWaitTx: begin
          if (moved) pending <= 1'b1;
          if (tx_ready) begin
            if (byte_idx_q == ByteLast) begin
              state_q <= StDone;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              tx_valid_q <= 1'b1;
              state_q    <= StSend;
            end
          end
        end
        StDone: begin
          pkt_count <= pkt_count + 16'd1;
          busy      <= 1'b0;
          if (pending) begin
            pending <= 1'b0;
            state_q <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .data    (tx_byte),
    .tx_valid(tx_valid_q),
    .tx_ready(tx_ready),
    .tx      (uart_out)
  );

endmodule
